// File: rtl/spi_clk_gen.sv
// SPI serial clock generator: divides sysclk into SCK with programmable half-period,
// idle polarity, graceful last-clock stop and one-cycle edge strobes.
module spi_clk_gen #(
   parameter int unsigned N = 8
) (
   input  logic         sysclk,
   input  logic         rst_n,
   input  logic         enable,
   input  logic         go,
   input  logic         CPOL,
   input  logic         last_clk,
   input  logic [N-1:0] divider_i,
   output logic         clk_out,
   output logic         pos_edge,
   output logic         neg_edge
);

   logic [N-1:0] cnt;
   logic [N-1:0] cnt_nxt;
   logic         clk_nxt;
   logic         pos_nxt;
   logic         neg_nxt;
   logic         active_c;
   logic         cnt_zero_c;
   logic         toggle_c;

   assign active_c   = enable & go;
   assign cnt_zero_c = (cnt == '0);
   // Under last_clk only the transition back to the idle level is permitted.
   assign toggle_c   = active_c & cnt_zero_c & (~last_clk | (clk_out != CPOL));

   // Next-state: reload on idle or half-period expiry, otherwise count down.
   always_comb begin
      cnt_nxt = cnt;
      clk_nxt = clk_out;
      pos_nxt = 1'b0;
      neg_nxt = 1'b0;
      if (!active_c) begin
         cnt_nxt = divider_i;
         clk_nxt = CPOL;
      end else begin
         if (cnt_zero_c) begin
            cnt_nxt = divider_i;
         end else begin
            cnt_nxt = cnt - N'(1);
         end
         if (toggle_c) begin
            clk_nxt = ~clk_out;
            pos_nxt = ~clk_out;
            neg_nxt = clk_out;
         end
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         clk_out  <= 1'b0;
         pos_edge <= 1'b0;
         neg_edge <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         clk_out  <= clk_nxt;
         pos_edge <= pos_nxt;
         neg_edge <= neg_nxt;
      end
   end

endmodule

// File: tb/tb_spi_clk_gen.sv
// Bench for spi_clk_gen: directed scenarios plus random traffic, compared each cycle
// against a half-period timing model of SCK.
module tb_spi_clk_gen;

   localparam int unsigned N = 8;

   logic         sysclk = 1'b0;
   logic         rst_n;
   logic         enable;
   logic         go;
   logic         CPOL;
   logic         last_clk;
   logic [N-1:0] divider_i;
   logic         clk_out;
   logic         pos_edge;
   logic         neg_edge;

   spi_clk_gen #(.N(N)) dut (
      .sysclk    (sysclk),
      .rst_n     (rst_n),
      .enable    (enable),
      .go        (go),
      .CPOL      (CPOL),
      .last_clk  (last_clk),
      .divider_i (divider_i),
      .clk_out   (clk_out),
      .pos_edge  (pos_edge),
      .neg_edge  (neg_edge)
   );

   always #5 sysclk = ~sysclk;

   int checks = 0;
   int fails  = 0;
   int n_pos  = 0;
   int n_neg  = 0;

   // Model: SCK level, strobes, and progress through the current half-period.
   logic m_clk;
   logic m_pos;
   logic m_neg;
   int   m_elapsed;
   int   m_half;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_clk     = 1'b0;
      m_pos     = 1'b0;
      m_neg     = 1'b0;
      m_elapsed = 0;
      m_half    = 1;
   endtask

   // One sysclk edge of the model, using the inputs presented before that edge.
   task automatic model_edge();
      m_pos = 1'b0;
      m_neg = 1'b0;
      if (!(enable && go)) begin
         m_clk     = CPOL;
         m_elapsed = 0;
         m_half    = int'(divider_i) + 1;
      end else begin
         m_elapsed++;
         if (m_elapsed >= m_half) begin
            if (!last_clk || (m_clk != CPOL)) begin
               m_pos = ~m_clk;
               m_neg = m_clk;
               m_clk = ~m_clk;
            end
            m_elapsed = 0;
            m_half    = int'(divider_i) + 1;
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge sysclk);
      #1;
      check("clk_out", clk_out, m_clk);
      check("pos_edge", pos_edge, m_pos);
      check("neg_edge", neg_edge, m_neg);
      if (pos_edge === 1'b1) n_pos++;
      if (neg_edge === 1'b1) n_neg++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int first;

      // Reset with CPOL=1: outputs forced low, then idle level after release.
      rst_n     = 1'b0;
      enable    = 1'b0;
      go        = 1'b0;
      CPOL      = 1'b1;
      last_clk  = 1'b0;
      divider_i = N'(4);
      model_reset();
      #2;
      check("rst_clk_out", clk_out, 1'b0);
      check("rst_pos_edge", pos_edge, 1'b0);
      check("rst_neg_edge", neg_edge, 1'b0);
      @(posedge sysclk);
      #1;
      rst_n = 1'b1;
      step();
      check("rst_exit_idle", clk_out, 1'b1);

      // Divider 4, CPOL=1: first falling edge 5 cycles after go.
      enable = 1'b1;
      step();
      go = 1'b1;
      steps(4);
      check("first_neg_early", neg_edge, 1'b0);
      step();
      check("first_neg_at5", neg_edge, 1'b1);
      check("first_neg_clk", clk_out, 1'b0);

      // Eight full SCK cycles in 80 sysclk cycles.
      n_pos = 0;
      n_neg = 0;
      steps(80);
      check_int("pos_in_80", n_pos, 8);
      check_int("neg_in_80", n_neg, 8);

      // Divider 0, CPOL=0: SCK toggles every cycle, strobes alternate.
      go = 1'b0;
      divider_i = N'(0);
      CPOL = 1'b0;
      step();
      go = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("div0_pos_alt", pos_edge, (i % 2 == 0) ? 1'b1 : 1'b0);
         check("div0_neg_alt", neg_edge, (i % 2 == 1) ? 1'b1 : 1'b0);
      end

      // last_clk while SCK is away from idle: one return transition, then silence.
      go = 1'b0;
      divider_i = N'(4);
      step();
      go = 1'b1;
      steps(5);
      check("lc_high_phase", clk_out, 1'b1);
      last_clk = 1'b1;
      n_pos = 0;
      n_neg = 0;
      steps(5);
      check("lc_returned", clk_out, 1'b0);
      steps(50);
      check_int("lc_pos_total", n_pos, 0);
      check_int("lc_neg_total", n_neg, 1);
      check("lc_idle_held", clk_out, 1'b0);
      last_clk = 1'b0;

      // Enable dropped mid-half-period, then re-enabled.
      steps(2);
      enable = 1'b0;
      step();
      check("dis_idle", clk_out, 1'b0);
      enable = 1'b1;
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if ((pos_edge === 1'b1) || (neg_edge === 1'b1)) begin
            first = i;
            break;
         end
      end
      check_int("reenable_latency", first, 5);

      // Maximum divider: half-period of 256 cycles.
      go = 1'b0;
      divider_i = N'(255);
      step();
      go = 1'b1;
      n_pos = 0;
      steps(255);
      check_int("maxdiv_no_edge", n_pos, 0);
      step();
      check("maxdiv_edge", pos_edge, 1'b1);

      // Randomised traffic, including divider changes mid-half-period.
      for (int i = 0; i < 600; i++) begin
         enable    = ($urandom_range(0, 19) != 0);
         go        = ($urandom_range(0, 14) != 0);
         last_clk  = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 7) == 0) divider_i = N'($urandom_range(0, 5));
         if (!(enable && go)) CPOL = 1'($urandom_range(0, 1));
         step();
         check("no_dual_pulse", pos_edge & neg_edge, 1'b0);
      end

      // Asynchronous reset mid-transfer, released with the transfer idle.
      enable    = 1'b1;
      go        = 1'b1;
      last_clk  = 1'b0;
      divider_i = N'(1);
      steps(3);
      #3;
      rst_n = 1'b0;
      go    = 1'b0;
      #1;
      model_reset();
      check("midrst_clk_out", clk_out, 1'b0);
      check("midrst_pos", pos_edge, 1'b0);
      check("midrst_neg", neg_edge, 1'b0);
      @(posedge sysclk);
      #1;
      rst_n = 1'b1;
      step();
      go = 1'b1;
      steps(20);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/spi_clk_gen.md
SPI_CLK_GEN -- requirements
Module: spi_clk_gen

Interface
REQ-001 Parameter: N, default 8, width of the divider input and the internal divide counter.
REQ-002 sysclk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 enable  input  1  module enable; low forces the idle state.
REQ-005 go  input  1  transfer active; high allows SCK toggling.
REQ-006 CPOL  input  1  clock polarity; idle level of clk_out.
REQ-007 last_clk  input  1  final-clock request; SCK finishes its current cycle, returns to idle, then stops.
REQ-008 divider_i  input  N  half-period divisor; SCK half-period = divider_i+1 sysclk cycles.
REQ-009 clk_out  output  1  SPI serial clock (SCK), registered.
REQ-010 pos_edge  output  1  one-sysclk pulse marking an SCK rising transition, registered.
REQ-011 neg_edge  output  1  one-sysclk pulse marking an SCK falling transition, registered.

Function
REQ-012 An internal N-bit down counter cnt is kept; cnt_zero = (cnt == 0).
REQ-013 active = enable & go.
REQ-014 When active is low: cnt loads divider_i, clk_out takes CPOL, and pos_edge and neg_edge are 0 on every cycle.
REQ-015 When active is high and cnt_zero is 0: cnt decrements by 1 and clk_out holds its value.
REQ-016 When active is high and cnt_zero is 1: cnt reloads divider_i.
REQ-017 toggle = active & cnt_zero & (!last_clk | (clk_out != CPOL)).
- If last_clk is high, only the transition back to the idle level is allowed.
REQ-018 On a toggle, clk_out inverts on that sysclk edge.
REQ-019 pos_edge is 1 for exactly the one sysclk cycle in which clk_out has just changed 0->1; otherwise it is 0.
REQ-020 neg_edge is 1 for exactly the one sysclk cycle in which clk_out has just changed 1->0; otherwise it is 0.
REQ-021 pos_edge and neg_edge are never 1 in the same cycle.
REQ-022 SCK period = 2*(divider_i+1) sysclk cycles.
- divider_i=0 gives toggling every cycle (period 2).
- divider_i=2^N-1 gives a half-period of 2^N cycles.
REQ-023 First-edge latency: after go rises, with enable high and cnt at divider_i, the first clk_out transition occurs divider_i+1 sysclk edges later.
- With CPOL=0 that first transition is rising (pos_edge); with CPOL=1 it is falling (neg_edge).
REQ-024 divider_i changes take effect at the next reload; a half-period already in progress is not shortened.
REQ-025 last_clk high while clk_out == CPOL: no further toggles occur and clk_out stays at CPOL until last_clk falls.
REQ-026 last_clk high while clk_out != CPOL: exactly one more toggle (back to CPOL) occurs at the next cnt_zero.
REQ-027 go or enable falling mid-cycle: clk_out returns to CPOL on the next sysclk edge with no edge pulse.
- cnt reloads divider_i.
REQ-028 CPOL changing while active is high only affects the last_clk stop condition; it shall not be changed during a transfer.

Reset
REQ-029 rst_n low asynchronously forces cnt=0, clk_out=0, pos_edge=0 and neg_edge=0.
REQ-030 On the first sysclk edge after rst_n releases with active low, clk_out takes CPOL and cnt loads divider_i.
REQ-031 Reset asserted mid-transfer aborts immediately; no edge pulse is generated on reset entry or exit.

Verification
REQ-032 Reset: rst_n=0, CPOL=1 -> clk_out=0, pos_edge=0, neg_edge=0; release rst_n with enable=0 -> clk_out=1 on the next edge.
REQ-033 Divider 4, CPOL=1, enable=1, go 0->1 -> first neg_edge 5 cycles later; clk_out period 10 cycles; pulses alternate and are 1 cycle wide.
REQ-034 Divider 0, CPOL=0 -> clk_out toggles every sysclk cycle; pos_edge and neg_edge alternate every cycle.
REQ-035 last_clk pulsed high while clk_out != CPOL, divider 4 -> exactly one more transition to CPOL, then clk_out stays constant for 50 cycles with no pulses.
REQ-036 enable dropped mid-half-period -> clk_out = CPOL on the next edge, no pulse; re-enable with go=1 -> first edge after divider_i+1 cycles.
REQ-037 Eight full SCK cycles, divider 4 -> exactly 8 pos_edge and 8 neg_edge pulses in 80 sysclk cycles.
